// File: rtl/ajc_risc_pkg.sv
// ajc_risc_pkg: shared opcodes, control-unit state encoding and writeback selects
package ajc_risc_pkg;
   localparam logic [3:0] OP_IO   = 4'hB;
   localparam logic [3:0] OP_LD   = 4'hC;
   localparam logic [3:0] OP_JCC  = 4'hD;
   localparam logic [3:0] OP_ST   = 4'hE;
   localparam logic [3:0] OP_HALT = 4'hF;
   localparam logic [3:0] OP_ALU_MAX = 4'hA;
   localparam logic [1:0] WB_ALU  = 2'd0;
   localparam logic [1:0] WB_DM   = 2'd1;
   localparam logic [1:0] WB_IPDR = 2'd2;
   typedef enum logic [3:0] {
      S_RST    = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_ADDR   = 4'd3,
      S_MEMLD  = 4'd4,
      S_MEMST  = 4'd5,
      S_JMP    = 4'd6,
      S_IOWB   = 4'd7,
      S_HALT   = 4'd8
   } state_t;
endpackage

// File: rtl/ajc_risc_cu_if.sv
// ajc_risc_cu_if: datapath control bus; master is the control unit, slave the datapath
interface ajc_risc_cu_if;
   logic [7:0] IW;
   logic [3:0] SR_CNVZ;
   logic RST_PC, LD_PC, CNT_PC, LD_IR;
   logic LD_R0, LD_R1, LD_R2, LD_R3;
   logic LD_TXR, LD_TYR, LD_TK;
   logic LD_SR, LD_MABR, LD_MAXR, LD_MAR;
   logic RW, LD_IPDR, LD_OPDR;
   logic [1:0] SRC1_SEL, SRC2_SEL, WB_SEL;
   logic [3:0] ALU_FS;
   logic [3:0] STATE;
   modport master(
      input  IW, SR_CNVZ,
      output RST_PC, LD_PC, CNT_PC, LD_IR, LD_R0, LD_R1, LD_R2, LD_R3,
             LD_TXR, LD_TYR, LD_TK, LD_SR, LD_MABR, LD_MAXR, LD_MAR,
             RW, LD_IPDR, LD_OPDR, SRC1_SEL, SRC2_SEL, WB_SEL, ALU_FS, STATE
   );
   modport slave(
      output IW, SR_CNVZ,
      input  RST_PC, LD_PC, CNT_PC, LD_IR, LD_R0, LD_R1, LD_R2, LD_R3,
             LD_TXR, LD_TYR, LD_TK, LD_SR, LD_MABR, LD_MAXR, LD_MAR,
             RW, LD_IPDR, LD_OPDR, SRC1_SEL, SRC2_SEL, WB_SEL, ALU_FS, STATE
   );
endinterface

// File: rtl/ajc_risc_cond.sv
// ajc_risc_cond: Jcc condition; cc[2] forces taken, cc[1:0] picks C/N/V/Z, cc[3] inverts
module ajc_risc_cond (
   input  logic [3:0] cc,
   input  logic [3:0] flags,
   output logic       taken
);
   // flags are packed C,N,V,Z from MSB, so selector 00 maps to bit 3
   assign taken = cc[2] | (flags[~cc[1:0]] ^ cc[3]);
endmodule

// File: rtl/ajc_risc_cu.sv
// ajc_risc_cu: multi-cycle Moore control unit for the 8-bit RISC core
// AJC_RISC_HALT_EN: opcode 0xF parks the core in S_HALT until reset
module ajc_risc_cu
   import ajc_risc_pkg::*;
(
   input logic           Clock,
   input logic           Reset,
   ajc_risc_cu_if.master dp
);
   state_t     state, nxt;
   logic       ld_ri, taken;
   logic [3:0] op;
   assign op = dp.IW[7:4];
   ajc_risc_cond u_cond (.cc(dp.IW[3:0]), .flags(dp.SR_CNVZ), .taken(taken));
   always_ff @(posedge Clock)
      if (Reset) state <= S_RST;
      else state <= nxt;
   always_comb begin
      nxt = S_FETCH;
      ld_ri = 1'b0;
      dp.RST_PC = 1'b0;
      dp.LD_PC = 1'b0;
      dp.CNT_PC = 1'b0;
      dp.LD_IR = 1'b0;
      dp.LD_SR = 1'b0;
      dp.LD_MABR = 1'b0;
      dp.LD_MAXR = 1'b0;
      dp.LD_MAR = 1'b0;
      dp.RW = 1'b0;
      dp.LD_IPDR = 1'b0;
      dp.LD_OPDR = 1'b0;
      dp.ALU_FS = 4'd0;
      dp.WB_SEL = WB_ALU;
      dp.SRC1_SEL = dp.IW[3:2];
      dp.SRC2_SEL = dp.IW[1:0];
      case (state)
         S_RST: begin
            dp.RST_PC = 1'b1;
            dp.SRC1_SEL = 2'd0;
            dp.SRC2_SEL = 2'd0;
         end
         S_FETCH: begin
            dp.LD_IR = 1'b1;
            dp.CNT_PC = 1'b1;
            nxt = S_DECODE;
         end
         S_DECODE:
            if (op <= OP_ALU_MAX) begin
               dp.ALU_FS = op;
               ld_ri = 1'b1;
               dp.LD_SR = 1'b1;
            end else if (op == OP_IO) begin
               dp.LD_IPDR = dp.IW[1:0] == 2'b00;
               dp.LD_OPDR = dp.IW[1:0] == 2'b01;
               nxt = dp.IW[1:0] == 2'b00 ? S_IOWB : S_FETCH;
            end else if (op == OP_LD || op == OP_ST || op == OP_JCC) begin
               dp.LD_MABR = 1'b1;
               dp.LD_MAXR = 1'b1;
               dp.CNT_PC = 1'b1;
               dp.SRC1_SEL = op == OP_JCC ? dp.IW[3:2] : dp.IW[1:0];
               nxt = S_ADDR;
            end
`ifdef AJC_RISC_HALT_EN
            else if (op == OP_HALT) nxt = S_HALT;
`endif
         S_ADDR: begin
            dp.LD_MAR = 1'b1;
            nxt = op == OP_LD ? S_MEMLD : op == OP_ST ? S_MEMST : op == OP_JCC ? S_JMP : S_FETCH;
         end
         S_MEMLD: begin
            dp.WB_SEL = WB_DM;
            ld_ri = 1'b1;
         end
         S_MEMST: dp.RW = 1'b1;
         S_JMP: dp.LD_PC = taken;
         S_IOWB: begin
            dp.WB_SEL = WB_IPDR;
            ld_ri = 1'b1;
         end
         S_HALT: nxt = S_HALT;
         default: nxt = S_RST;
      endcase
   end
   assign dp.LD_R0 = ld_ri & (dp.IW[3:2] == 2'd0);
   assign dp.LD_R1 = ld_ri & (dp.IW[3:2] == 2'd1);
   assign dp.LD_R2 = ld_ri & (dp.IW[3:2] == 2'd2);
   assign dp.LD_R3 = ld_ri & (dp.IW[3:2] == 2'd3);
   assign dp.LD_TXR = 1'b0;
   assign dp.LD_TYR = 1'b0;
   assign dp.LD_TK = 1'b0;
   assign dp.STATE = state;
endmodule

// File: tb/tb_ajc_risc_cu.sv
// tb_ajc_risc_cu: random instruction stream checked cycle by cycle against a per-instruction timing model
module tb_ajc_risc_cu;
   import ajc_risc_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail = 0;
   ajc_risc_cu_if bus();
   ajc_risc_cu dut (.Clock(clk), .Reset(rst), .dp(bus));
   always #5 clk = ~clk;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   function automatic logic [27:0] pk(logic [3:0] ctl, logic [3:0] ldr, logic [9:0] misc,
                                      logic [1:0] s1, logic [1:0] s2, logic [1:0] wb, logic [3:0] fs);
      return {ctl, ldr, misc, s1, s2, wb, fs};
   endfunction

   function automatic logic [27:0] obs();
      return pk({bus.RST_PC, bus.LD_PC, bus.CNT_PC, bus.LD_IR},
                {bus.LD_R3, bus.LD_R2, bus.LD_R1, bus.LD_R0},
                {bus.LD_TXR, bus.LD_TYR, bus.LD_TK, bus.LD_SR, bus.LD_MABR, bus.LD_MAXR,
                 bus.LD_MAR, bus.RW, bus.LD_IPDR, bus.LD_OPDR},
                bus.SRC1_SEL, bus.SRC2_SEL, bus.WB_SEL, bus.ALU_FS);
   endfunction

   function automatic logic jcc(logic [7:0] iw, logic [3:0] fl);
      logic f;
      case (iw[1:0])
         2'd0: f = fl[3];
         2'd1: f = fl[2];
         2'd2: f = fl[1];
         default: f = fl[0];
      endcase
      return iw[2] ? 1'b1 : f ^ iw[3];
   endfunction

   function automatic int ncyc(logic [7:0] iw);
      int op = int'(iw[7:4]);
      if (op <= 10) return 2;
      if (op == 11) return iw[1:0] == 2'b00 ? 3 : 2;
      if (op <= 14) return 4;
      return 2;
   endfunction

   // expected outputs in cycle k of an instruction (k=0 is its fetch)
   function automatic logic [27:0] model(logic [7:0] iw, logic [3:0] fl, int k);
      logic [3:0] ctl = 4'd0, ldr = 4'd0, fs = 4'd0, hot;
      logic [9:0] misc = 10'd0;
      logic [1:0] s1 = iw[3:2], s2 = iw[1:0], wb = 2'd0;
      int op = int'(iw[7:4]);
      hot = 4'b0001 << iw[3:2];
      if (op == 15 && k >= 2) return pk(ctl, ldr, misc, s1, s2, wb, fs);
      if (k == 0) ctl = 4'b0011;
      else if (k == 1) begin
         if (op <= 10) begin fs = iw[7:4]; ldr = hot; misc[6] = 1'b1; end
         else if (op == 11) begin misc[1] = iw[1:0] == 2'd0; misc[0] = iw[1:0] == 2'd1; end
         else if (op <= 14) begin
            misc[5] = 1'b1; misc[4] = 1'b1; ctl[1] = 1'b1;
            if (op != 13) s1 = iw[1:0];
         end
      end else if (k == 2) begin
         if (op == 11) begin wb = 2'd2; ldr = hot; end
         else misc[3] = 1'b1;
      end else begin
         if (op == 12) begin wb = 2'd1; ldr = hot; end
         else if (op == 14) misc[2] = 1'b1;
         else ctl[2] = jcc(iw, fl);
      end
      return pk(ctl, ldr, misc, s1, s2, wb, fs);
   endfunction

   task automatic rst_seq();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_out", 32'(obs()), 32'(pk(4'b1000, 4'd0, 10'd0, 2'd0, 2'd0, 2'd0, 4'd0)));
      check("rst_state", 32'(bus.STATE), 32'd0);
   endtask

   // fl < 0 randomizes flags every cycle; cut >= 0 asserts reset after that cycle
   task automatic run(logic [7:0] iw, int fl, int cut);
      int n = ncyc(iw);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         bus.IW = iw;
         bus.SR_CNVZ = fl < 0 ? 4'($urandom) : 4'(fl);
         #1;
         check($sformatf("iw%02h_c%0d", iw, k), 32'(obs()), 32'(model(iw, bus.SR_CNVZ, k)));
         if (k == cut) begin
            rst_seq();
            return;
         end
      end
   endtask

   initial begin
      logic [7:0] iw;
      int cut;
      bus.IW = 8'h00;
      bus.SR_CNVZ = 4'h0;
      rst_seq();
      run(8'h06, -1, -1);
      run(8'hC7, -1, -1);
      run(8'hE8, -1, -1);
      run(8'hD3, 1, -1);
      run(8'hD3, 0, -1);
      run(8'hDB, 1, -1);
      run(8'hDB, 0, -1);
      run(8'hD4, 0, -1);
      run(8'hB0, -1, -1);
      run(8'hBD, -1, -1);
      run(8'hE8, -1, 2);
`ifndef AJC_RISC_HALT_EN
      run(8'hF0, -1, -1);
`endif
      for (int i = 0; i < 400; i++) begin
         iw = 8'($urandom);
`ifdef AJC_RISC_HALT_EN
         if (iw[7:4] == 4'hF) iw[7:4] = 4'hE;
`endif
         cut = $urandom_range(0, 7) == 0 ? $urandom_range(0, ncyc(iw) - 1) : -1;
         run(iw, -1, cut);
      end
`ifdef AJC_RISC_HALT_EN
      run(8'hF0, -1, -1);
      for (int k = 2; k < 7; k++) begin
         @(negedge clk);
         bus.SR_CNVZ = 4'($urandom);
         #1;
         check("halt_out", 32'(obs()), 32'(model(8'hF0, bus.SR_CNVZ, k)));
         check("halt_state", 32'(bus.STATE), 32'(S_HALT));
      end
      rst_seq();
      run(8'h06, -1, -1);
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
